// File: rtl/mod_mul_iter.sv
// mod_mul_iter: iterative modular multiplier, p = (a * b) mod n, WIDTH-bit operands.
// MSB-first interleaved shift-add-reduce, one bit per cycle, valid/ready on both sides.
// Optional feature macro: MOD_MUL_ITER_PREREDUCE_EN
//   defined   : b is first reduced mod n (REDUCE phase), so b may be >= n.
//   undefined : b is used directly (caller keeps b < n); IDLE goes straight to MUL.
// err = 1 with p = 0 reports n == 0.
module mod_mul_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_MUL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // holds b, then Bred once REDUCE finishes
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] step_x;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] n1;
  logic [WIDTH+1:0] n2;

  // Addend for this cycle: bit of b while reducing, a[i] ? Bred : 0 while multiplying
  always_comb begin
    step_x = '0;
    if (state == S_REDUCE) begin
      step_x = {{(WIDTH-1){1'b0}}, b_q[cnt]};
    end else if (a_q[cnt]) begin
      step_x = b_q;
    end
  end

  // Single-cycle reduction of T = 2R + x (< 3N) into [0, N)
  always_comb begin
    t     = {1'b0, r_q, 1'b0} + {2'b00, step_x};
    n1    = {2'b00, n_q};
    n2    = {1'b0, n_q, 1'b0};
    r_nxt = WIDTH'(t);
    if (t >= n2) begin
      r_nxt = WIDTH'(t - n2);
    end else if (t >= n1) begin
      r_nxt = WIDTH'(t - n1);
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            n_q      <= n;
            r_q      <= '0;
            cnt      <= CNT_TOP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (n == '0) begin
              state <= S_DONE;
              err   <= 1'b1;
            end else begin
`ifdef MOD_MUL_ITER_PREREDUCE_EN
              state <= S_REDUCE;
`else
              state <= S_MUL;
`endif
            end
          end
        end

        S_REDUCE: begin
          if (cnt == '0) begin
            b_q   <= r_nxt;
            r_q   <= '0;
            cnt   <= CNT_TOP;
            state <= S_MUL;
          end else begin
            r_q <= r_nxt;
            cnt <= cnt - CW'(1);
          end
        end

        S_MUL: begin
          r_q <= r_nxt;
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            p         <= err ? '0 : r_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
